// File: rtl/load_store_unit.sv
`default_nettype none
//==============================================================================
// Module      : load_store_unit
// Description : Data-memory initiator. Runs one load/store at a time, uses
//               read-modify-write for sb/sh and sign/zero-extends load data.
// Revision    : 1.0 - initial release
//==============================================================================
module load_store_unit #(
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int REG_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    // request from the core
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [2:0]                 req_funct3,
    input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0]       req_wdata,
    // response to the core
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [REG_WIDTH-1:0]       rsp_rdata,
    output logic                       rsp_err,
    // data memory
    output logic                       mem_wr_en,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]       mem_wr_data,
    input  logic [REG_WIDTH-1:0]       mem_rd_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]                 r_state;
    logic                       r_we;
    logic [2:0]                 r_funct3;
    logic [DMEM_ADDR_WIDTH-1:0] r_addr;
    logic [15:0]                r_wdata_lo;
    logic [REG_WIDTH-1:0]       r_mem_wr_data;
    logic [REG_WIDTH-1:0]       r_rsp_rdata;
    logic                       r_rsp_err;

    logic                       w_illegal;
    logic                       w_misaligned;
    logic [7:0]                 w_byte;
    logic [15:0]                w_half;
    logic [REG_WIDTH-1:0]       w_load_data;
    logic [REG_WIDTH-1:0]       w_merge_data;

    // Legality and alignment of the incoming request (evaluated in IDLE only)
    always_comb begin
        w_illegal = 1'b0;
        if (req_we) begin
            w_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
        end
        w_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    // Lane selection and extension of the word coming back from memory
    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = mem_rd_data[7:0];
            2'b01:   w_byte = mem_rd_data[15:8];
            2'b10:   w_byte = mem_rd_data[23:16];
            default: w_byte = mem_rd_data[31:24];
        endcase
        w_half = r_addr[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rd_data;
        endcase
    end

    // Sub-word store: splice the new byte/half into the sampled word
    always_comb begin
        w_merge_data = mem_rd_data;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_addr[1:0])
                2'b00:   w_merge_data[7:0]   = r_wdata_lo[7:0];
                2'b01:   w_merge_data[15:8]  = r_wdata_lo[7:0];
                2'b10:   w_merge_data[23:16] = r_wdata_lo[7:0];
                default: w_merge_data[31:24] = r_wdata_lo[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge_data[31:16] = r_wdata_lo;
        end else begin
            w_merge_data[15:0] = r_wdata_lo;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_we          <= 1'b0;
            r_funct3      <= 3'd0;
            r_addr        <= '0;
            r_wdata_lo    <= 16'd0;
            r_mem_wr_data <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_funct3    <= req_funct3;
                        r_addr      <= req_addr;
                        r_wdata_lo  <= req_wdata[15:0];
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        if (w_illegal || w_misaligned) begin
                            r_rsp_err <= 1'b1;
                            r_state   <= S_RESP;
                        end else if (req_we && (req_funct3 == 3'b010)) begin
                            r_mem_wr_data <= req_wdata;
                            r_state       <= S_WR;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (r_we) begin
                        r_mem_wr_data <= w_merge_data;
                        r_state       <= S_WR;
                    end else begin
                        r_rsp_rdata <= w_load_data;
                        r_state     <= S_RESP;
                    end
                end
                S_WR: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write enable decodes the state register, so an async reset drops it at once
    assign mem_wr_en   = (r_state == S_WR);
    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign mem_addr    = {r_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
    assign mem_wr_data = r_mem_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               behavioural word memory.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_load_store_unit;

    localparam int AW = 10;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wr_data;
    logic [31:0]   mem_rd_data;

    logic [31:0]   mem [0:255];

    int n_cmp;
    int n_fail;

    load_store_unit #(.DMEM_ADDR_WIDTH(AW), .REG_WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem_rd_data = 32'd0;
    end

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[9:2]] <= mem_wr_data;
    end

    always @(negedge clk) begin
        mem_rd_data <= mem_wr_en ? 32'd0 : mem[mem_addr[9:2]];
    end

    // Issue one request from IDLE; report latency, response and write pulses
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                          input logic [31:0] wd, output int cyc, output logic [31:0] rd,
                          output logic er, output int wrs);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 1;
        wrs = 0;
        while (!rsp_valid && cyc < 20) begin
            if (mem_wr_en) wrs++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!rsp_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: no rsp_valid within %0d cycles (addr %h)", cyc, addr);
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, mem_wr_en} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/vld/err/wen=%b expected 1000",
                     {req_ready, rsp_valid, rsp_err, mem_wr_en});
        end
        n_cmp++;
        if ({rsp_rdata, mem_wr_data} !== 64'd0 || mem_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h wdata=%h addr=%h expected all 0",
                     rsp_rdata, mem_wr_data, mem_addr);
        end
    endtask

    task automatic test_word();
        int cyc, wrs;
        logic [31:0] rd;
        logic er;
        do_req(1'b1, 3'b010, 10'h10, 32'hDEADBEEF, cyc, rd, er, wrs);
        n_cmp++;
        if (cyc !== 2 || wrs !== 1 || er !== 1'b0 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL sw_0x10: got cyc=%0d wr=%0d err=%b rdata=%h expected 2 1 0 0",
                     cyc, wrs, er, rd);
        end
        do_req(1'b0, 3'b010, 10'h10, 32'd0, cyc, rd, er, wrs);
        n_cmp++;
        if (cyc !== 2 || wrs !== 0 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lw_0x10: got cyc=%0d wr=%0d err=%b rdata=%h expected 2 0 0 deadbeef",
                     cyc, wrs, er, rd);
        end
    endtask

    task automatic test_subword();
        int cyc, wrs;
        logic [31:0] rd;
        logic er;
        do_req(1'b1, 3'b000, 10'h11, 32'hFFFFFF55, cyc, rd, er, wrs);
        n_cmp++;
        if (cyc !== 3 || wrs !== 1 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_0x11: got cyc=%0d wr=%0d err=%b expected 3 1 0", cyc, wrs, er);
        end
        do_req(1'b0, 3'b010, 10'h10, 32'd0, cyc, rd, er, wrs);
        n_cmp++;
        if (rd !== 32'hDEAD55EF) begin
            n_fail++;
            $display("FAIL sb_result: got %h expected dead55ef", rd);
        end
        do_req(1'b1, 3'b001, 10'h12, 32'hABCD1234, cyc, rd, er, wrs);
        n_cmp++;
        if (cyc !== 3 || wrs !== 1 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_0x12: got cyc=%0d wr=%0d err=%b expected 3 1 0", cyc, wrs, er);
        end
        do_req(1'b0, 3'b010, 10'h10, 32'd0, cyc, rd, er, wrs);
        n_cmp++;
        if (rd !== 32'h123455EF) begin
            n_fail++;
            $display("FAIL sh_result: got %h expected 123455ef", rd);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, wrs;
        logic [31:0] rd;
        logic er;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 10'h10;
        req_wdata  = 32'h0000AAAA;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (mem_wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_in_wr: got mem_wr_en=%b expected 1", mem_wr_en);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, mem_wr_en} !== 4'b1000 || mem_addr !== 10'd0 ||
            mem_wr_data !== 32'd0 || rsp_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got flags=%b addr=%h wdata=%h rdata=%h expected 1000 0 0 0",
                     {req_ready, rsp_valid, rsp_err, mem_wr_en}, mem_addr, mem_wr_data, rsp_rdata);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        n_cmp++;
        if (mem[4] !== 32'h123455EF) begin
            n_fail++;
            $display("FAIL rmid_mem: got %h expected 123455ef", mem[4]);
        end
        do_req(1'b0, 3'b010, 10'h10, 32'd0, cyc, rd, er, wrs);
        n_cmp++;
        if (rd !== 32'h123455EF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_lw: got %h err=%b expected 123455ef 0", rd, er);
        end
    endtask

    task automatic test_extension();
        int cyc, wrs;
        logic [31:0] rd;
        logic er;
        logic [2:0]    f3s  [5] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101};
        logic [AW-1:0] adrs [5] = '{10'h0, 10'h0, 10'h1, 10'h2, 10'h2};
        logic [31:0]   exps [5] = '{32'hFFFFFF81, 32'h00000081, 32'h0000007F,
                                    32'hFFFF80F0, 32'h000080F0};
        do_req(1'b1, 3'b010, 10'h0, 32'h80F07F81, cyc, rd, er, wrs);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3s[i], adrs[i], 32'd0, cyc, rd, er, wrs);
            n_cmp++;
            if (rd !== exps[i] || er !== 1'b0 || cyc !== 2) begin
                n_fail++;
                $display("FAIL ext_%0d (f3=%b addr=%h): got %h err=%b cyc=%0d expected %h 0 2",
                         i, f3s[i], adrs[i], rd, er, cyc, exps[i]);
            end
        end
    endtask

    task automatic test_errors();
        int cyc, wrs;
        logic [31:0] rd;
        logic er;
        logic          wes  [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]    f3s  [3] = '{3'b010, 3'b001, 3'b011};
        logic [AW-1:0] adrs [3] = '{10'h6, 10'h3, 10'h0};
        for (int i = 0; i < 3; i++) begin
            do_req(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, cyc, rd, er, wrs);
            n_cmp++;
            if (er !== 1'b1 || rd !== 32'd0 || cyc !== 1 || wrs !== 0) begin
                n_fail++;
                $display("FAIL err_%0d: got err=%b rdata=%h cyc=%0d wr=%0d expected 1 0 1 0",
                         i, er, rd, cyc, wrs);
            end
        end
        do_req(1'b0, 3'b010, 10'h0, 32'd0, cyc, rd, er, wrs);
        n_cmp++;
        if (rd !== 32'h80F07F81) begin
            n_fail++;
            $display("FAIL err_mem_intact: got %h expected 80f07f81", rd);
        end
    endtask

    task automatic test_backpressure();
        int cyc, wrs;
        logic [31:0] rd;
        logic er;
        rsp_ready = 1'b0;
        do_req(1'b0, 3'b010, 10'h10, 32'd0, cyc, rd, er, wrs);
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 10'h0;
        req_wdata  = 32'h0;
        req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h123455EF || req_ready !== 1'b0 ||
                mem_wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got vld=%b rdata=%h rdy=%b wen=%b expected 1 123455ef 0 0",
                         i, rsp_valid, rsp_rdata, req_ready, mem_wr_en);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", rsp_valid, req_ready);
        end
        do_req(1'b0, 3'b010, 10'h0, 32'd0, cyc, rd, er, wrs);
        n_cmp++;
        if (rd !== 32'h80F07F81 || cyc !== 2) begin
            n_fail++;
            $display("FAIL bp_after: got %h cyc=%0d expected 80f07f81 2", rd, cyc);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_word();
        test_subword();
        test_reset_mid();
        test_extension();
        test_errors();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
